// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Inter-stage pipeline register with a valid/ready handshake.
//               Carries payload, PC, branch-delay flag and ExcCode. Has an
//               optional 2-entry skid buffer so that in_ready comes straight
//               from a flop. Synchronous flush kills every held entry.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
  parameter int unsigned DATA_W         = 160,
  parameter int unsigned EXC_W          = 5,
  parameter logic [31:0] PC_RESET       = 32'h0000_3000,
  parameter bit          SKID_EN        = 1'b1,
  parameter bit          BUBBLE_KEEP_PC = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_bd,
  input  logic [EXC_W-1:0]  in_exc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_bd,
  output logic [EXC_W-1:0]  out_exc,
  output logic [1:0]        occupancy
);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // Main entry: this is what the downstream stage sees.
  logic [31:0]       r_main_pc;
  logic [DATA_W-1:0] r_main_data;
  logic              r_main_bd;
  logic [EXC_W-1:0]  r_main_exc;

  // Skid entry view (real flops only when the skid buffer is built).
  logic [31:0]       w_skid_pc;
  logic [DATA_W-1:0] w_skid_data;
  logic              w_skid_bd;
  logic [EXC_W-1:0]  w_skid_exc;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_emit;
  logic              w_kill;

  // Register-update strobes decoded by the FSM.
  logic              w_load_main_in;
  logic              w_load_main_skid;
  logic              w_load_skid;
  logic              w_bubble;

  assign w_kill      = rst | flush;
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_accept    = in_valid & w_in_ready;
  assign w_emit      = w_out_valid & out_ready;

  // State register; reset and flush both return the stage to EMPTY.
  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and register-update strobes.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_bubble         = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = ST_FULL;
          w_load_main_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_accept && w_emit) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          // Only reachable with the skid buffer: without it in_ready
          // is low whenever FULL and stalled.
          w_state_nxt = ST_SKID;
          w_load_skid = 1'b1;
        end else if (w_emit) begin
          w_state_nxt = ST_EMPTY;
          w_bubble    = 1'b1;
        end
      end
      ST_SKID: begin
        if (w_emit) begin
          w_state_nxt      = ST_FULL;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Main entry: load from input or skid, or turn into a drain bubble.
  always_ff @(posedge clk) begin
    if (w_kill) begin
      r_main_pc   <= PC_RESET;
      r_main_data <= '0;
      r_main_bd   <= 1'b0;
      r_main_exc  <= '0;
    end else if (w_load_main_in) begin
      r_main_pc   <= in_pc;
      r_main_data <= in_data;
      r_main_bd   <= in_bd;
      r_main_exc  <= in_exc;
    end else if (w_load_main_skid) begin
      r_main_pc   <= w_skid_pc;
      r_main_data <= w_skid_data;
      r_main_bd   <= w_skid_bd;
      r_main_exc  <= w_skid_exc;
    end else if (w_bubble) begin
      // Bubbles carry no payload; the PC either stays for EPC use
      // or snaps back to the reset vector.
      r_main_data <= '0;
      r_main_exc  <= '0;
      if (!BUBBLE_KEEP_PC) begin
        r_main_pc <= PC_RESET;
        r_main_bd <= 1'b0;
      end
    end
  end

  generate
    if (SKID_EN) begin : g_skid
      logic [31:0]       r_skid_pc;
      logic [DATA_W-1:0] r_skid_data;
      logic              r_skid_bd;
      logic [EXC_W-1:0]  r_skid_exc;
      logic              r_in_ready;

      // Skid entry catches the beat that arrives while the output stalls.
      always_ff @(posedge clk) begin
        if (w_kill || w_load_main_skid) begin
          r_skid_pc   <= '0;
          r_skid_data <= '0;
          r_skid_bd   <= 1'b0;
          r_skid_exc  <= '0;
        end else if (w_load_skid) begin
          r_skid_pc   <= in_pc;
          r_skid_data <= in_data;
          r_skid_bd   <= in_bd;
          r_skid_exc  <= in_exc;
        end
      end

      // Registered ready: low exactly while the skid entry is occupied,
      // so there is no combinational path from out_ready.
      always_ff @(posedge clk) begin
        if (w_kill) begin
          r_in_ready <= 1'b1;
        end else begin
          r_in_ready <= (w_state_nxt != ST_SKID);
        end
      end

      assign w_skid_pc   = r_skid_pc;
      assign w_skid_data = r_skid_data;
      assign w_skid_bd   = r_skid_bd;
      assign w_skid_exc  = r_skid_exc;
      assign w_in_ready  = r_in_ready;
    end else begin : g_no_skid
      // Single entry: accept when empty or when the held beat leaves now.
      assign w_skid_pc   = '0;
      assign w_skid_data = '0;
      assign w_skid_bd   = 1'b0;
      assign w_skid_exc  = '0;
      assign w_in_ready  = (r_state == ST_EMPTY) | out_ready;
    end
  endgenerate

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_pc    = r_main_pc;
  assign out_data  = r_main_data;
  assign out_bd    = r_main_bd;
  assign out_exc   = r_main_exc;
  assign occupancy = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Self-checking bench for pipe_stage_skid. Three instances:
//               default (skid, keep PC), bubble-resets-PC, and no-skid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

  localparam int DW = 160;

  typedef struct {
    logic [31:0]   pc;
    logic [DW-1:0] data;
    logic          bd;
    logic [4:0]    exc;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;

  // Shared stimulus for the skid instances.
  logic          in_valid = 1'b0;
  logic [31:0]   in_pc = '0;
  logic [DW-1:0] in_data = '0;
  logic          in_bd = 1'b0;
  logic [4:0]    in_exc = '0;
  logic          out_ready = 1'b0;

  logic          in_ready, out_valid, out_bd;
  logic [31:0]   out_pc;
  logic [DW-1:0] out_data;
  logic [4:0]    out_exc;
  logic [1:0]    occupancy;

  logic          nk_in_ready, nk_out_valid, nk_out_bd;
  logic [31:0]   nk_out_pc;
  logic [DW-1:0] nk_out_data;
  logic [4:0]    nk_out_exc;
  logic [1:0]    nk_occupancy;

  // Stimulus for the no-skid instance.
  logic          ns_in_valid = 1'b0;
  logic [31:0]   ns_in_pc = '0;
  logic [DW-1:0] ns_in_data = '0;
  logic          ns_in_bd = 1'b0;
  logic [4:0]    ns_in_exc = '0;
  logic          ns_out_ready = 1'b0;

  logic          ns_in_ready, ns_out_valid, ns_out_bd;
  logic [31:0]   ns_out_pc;
  logic [DW-1:0] ns_out_data;
  logic [4:0]    ns_out_exc;
  logic [1:0]    ns_occupancy;

  int n_checks = 0;
  int n_errors = 0;

  beat_t exp_q[$];
  beat_t ns_q[$];

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .EXC_W(5), .PC_RESET(32'h0000_3000),
                    .SKID_EN(1'b1), .BUBBLE_KEEP_PC(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_data(in_data),
    .in_bd(in_bd), .in_exc(in_exc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_data(out_data),
    .out_bd(out_bd), .out_exc(out_exc), .occupancy(occupancy)
  );

  pipe_stage_skid #(.DATA_W(DW), .EXC_W(5), .PC_RESET(32'h0000_3000),
                    .SKID_EN(1'b1), .BUBBLE_KEEP_PC(1'b0)) dut_nk (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(nk_in_ready), .in_pc(in_pc), .in_data(in_data),
    .in_bd(in_bd), .in_exc(in_exc),
    .out_valid(nk_out_valid), .out_ready(out_ready), .out_pc(nk_out_pc),
    .out_data(nk_out_data), .out_bd(nk_out_bd), .out_exc(nk_out_exc),
    .occupancy(nk_occupancy)
  );

  pipe_stage_skid #(.DATA_W(DW), .EXC_W(5), .PC_RESET(32'h0000_3000),
                    .SKID_EN(1'b0), .BUBBLE_KEEP_PC(1'b1)) dut_ns (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(ns_in_valid), .in_ready(ns_in_ready), .in_pc(ns_in_pc),
    .in_data(ns_in_data), .in_bd(ns_in_bd), .in_exc(ns_in_exc),
    .out_valid(ns_out_valid), .out_ready(ns_out_ready), .out_pc(ns_out_pc),
    .out_data(ns_out_data), .out_bd(ns_out_bd), .out_exc(ns_out_exc),
    .occupancy(ns_occupancy)
  );

  function automatic logic [DW-1:0] mk_data(input logic [31:0] pc);
    return {pc, ~pc, pc ^ 32'h1234_5678, 32'hDEAD_BEEF, pc + 32'd1};
  endfunction

  task automatic drive_beat(input beat_t b);
    in_valid = 1'b1;
    in_pc    = b.pc;
    in_data  = b.data;
    in_bd    = b.bd;
    in_exc   = b.exc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h3000 || out_data !== '0 ||
        out_exc !== 5'd0 || out_bd !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset: valid=%b pc=%h data0=%b exc=%h bd=%b occ=%0d rdy=%b, need 0 3000 1 0 0 0 1",
               out_valid, out_pc, (out_data == '0), out_exc, out_bd, occupancy, in_ready);
    end
    n_checks++;
    if (nk_out_pc !== 32'h3000 || nk_out_valid !== 1'b0 || nk_in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_nk: pc=%h valid=%b rdy=%b, need 3000 0 1", nk_out_pc, nk_out_valid, nk_in_ready);
    end
    n_checks++;
    if (ns_in_ready !== 1'b1 || ns_occupancy !== 2'd0 || ns_out_pc !== 32'h3000) begin
      n_errors++;
      $display("FAIL reset_ns: rdy=%b occ=%0d pc=%h, need 1 0 3000", ns_in_ready, ns_occupancy, ns_out_pc);
    end
  endtask

  task automatic test_streaming();
    beat_t e, g;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        e.pc = 32'h3000 + 32'(4 * i);
        e.data = mk_data(e.pc);
        e.bd = i[0];
        e.exc = 5'(i + 1);
        drive_beat(e);
        exp_q.push_back(e);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < 3) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_errors++;
          $display("FAIL stream_ready[%0d]: got %b need 1", i, in_ready);
        end
      end
      if (i >= 1 && i <= 3) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL stream_sb_empty[%0d]: scoreboard empty", i);
        end else begin
          g = exp_q.pop_front();
          if (out_valid !== 1'b1 || occupancy !== 2'd1 || out_pc !== g.pc ||
              out_data !== g.data || out_bd !== g.bd || out_exc !== g.exc) begin
            n_errors++;
            $display("FAIL stream_beat[%0d]: valid=%b occ=%0d pc=%h bd=%b exc=%h, need 1 1 %h %b %h",
                     i, out_valid, occupancy, out_pc, out_bd, out_exc, g.pc, g.bd, g.exc);
          end
        end
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_pc !== 32'h3008 || out_data !== '0) begin
      n_errors++;
      $display("FAIL stream_drain: valid=%b occ=%0d pc=%h, need 0 0 3008", out_valid, occupancy, out_pc);
    end
  endtask

  task automatic test_stall();
    beat_t e, g;
    out_ready = 1'b0;
    e.pc = 32'h3000; e.data = mk_data(e.pc); e.bd = 1'b0; e.exc = 5'd3;
    drive_beat(e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    e.pc = 32'h3004; e.data = mk_data(e.pc); e.bd = 1'b1; e.exc = 5'd4;
    drive_beat(e);
    exp_q.push_back(e);
    n_checks++;
    if (in_ready !== 1'b1 || occupancy !== 2'd1) begin
      n_errors++;
      $display("FAIL stall_full: rdy=%b occ=%0d, need 1 1", in_ready, occupancy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (in_ready !== 1'b0 || occupancy !== 2'd2 || out_valid !== 1'b1 ||
          out_pc !== 32'h3000 || out_data !== mk_data(32'h3000)) begin
        n_errors++;
        $display("FAIL stall_skid[%0d]: rdy=%b occ=%0d valid=%b pc=%h, need 0 2 1 3000",
                 i, in_ready, occupancy, out_valid, out_pc);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL stall_sb_empty[%0d]: scoreboard empty", i);
      end else begin
        g = exp_q.pop_front();
        if (out_valid !== 1'b1 || occupancy !== 2'(2 - i) || out_pc !== g.pc ||
            out_data !== g.data || out_bd !== g.bd || out_exc !== g.exc) begin
          n_errors++;
          $display("FAIL stall_drain[%0d]: valid=%b occ=%0d pc=%h bd=%b, need 1 %0d %h %b",
                   i, out_valid, occupancy, out_pc, out_bd, 2 - i, g.pc, g.bd);
        end
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_empty: valid=%b occ=%0d rdy=%b, need 0 0 1", out_valid, occupancy, in_ready);
    end
  endtask

  task automatic test_flush();
    beat_t e;
    out_ready = 1'b0;
    e.pc = 32'h3000; e.data = mk_data(e.pc); e.bd = 1'b0; e.exc = 5'd1;
    drive_beat(e);
    @(posedge clk); #1;
    e.pc = 32'h3004; e.data = mk_data(e.pc); e.bd = 1'b0; e.exc = 5'd2;
    drive_beat(e);
    @(posedge clk); #1;
    n_checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_pre: occ=%0d rdy=%b, need 2 0", occupancy, in_ready);
    end
    flush = 1'b1;
    e.pc = 32'h300C; e.data = mk_data(e.pc); e.bd = 1'b1; e.exc = 5'd9;
    drive_beat(e);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h3000 || out_data !== '0 ||
        occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_state: valid=%b pc=%h data0=%b occ=%0d rdy=%b, need 0 3000 1 0 1",
               out_valid, out_pc, (out_data == '0), occupancy, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_pc === 32'h300C) begin
        n_errors++;
        $display("FAIL flush_leak[%0d]: valid=%b pc=%h, need 0 and not 300c", i, out_valid, out_pc);
      end
    end
  endtask

  task automatic test_bubble();
    beat_t e, g;
    out_ready = 1'b1;
    e.pc = 32'h3010; e.data = mk_data(e.pc); e.bd = 1'b1; e.exc = 5'd7;
    drive_beat(e);
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    g = exp_q.pop_front();
    if (out_valid !== 1'b1 || out_pc !== g.pc || out_bd !== g.bd || out_exc !== g.exc ||
        nk_out_pc !== g.pc || nk_out_bd !== 1'b1) begin
      n_errors++;
      $display("FAIL bubble_beat: pc=%h bd=%b nk_pc=%h nk_bd=%b, need 3010 1 3010 1",
               out_pc, out_bd, nk_out_pc, nk_out_bd);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h3010 || out_bd !== 1'b1 ||
        out_data !== '0 || out_exc !== 5'd0) begin
      n_errors++;
      $display("FAIL bubble_keep: valid=%b pc=%h bd=%b data0=%b exc=%h, need 0 3010 1 1 0",
               out_valid, out_pc, out_bd, (out_data == '0), out_exc);
    end
    n_checks++;
    if (nk_out_valid !== 1'b0 || nk_out_pc !== 32'h3000 || nk_out_bd !== 1'b0 ||
        nk_out_data !== '0 || nk_out_exc !== 5'd0) begin
      n_errors++;
      $display("FAIL bubble_reset_pc: valid=%b pc=%h bd=%b data0=%b, need 0 3000 0 1",
               nk_out_valid, nk_out_pc, nk_out_bd, (nk_out_data == '0));
    end
  endtask

  task automatic test_rst_priority();
    beat_t e;
    out_ready = 1'b0;
    e.pc = 32'h3020; e.data = mk_data(e.pc); e.bd = 1'b1; e.exc = 5'd5;
    drive_beat(e);
    @(posedge clk); #1;
    e.pc = 32'h3024; e.data = mk_data(e.pc); e.bd = 1'b0; e.exc = 5'd6;
    drive_beat(e);
    @(posedge clk); #1;
    n_checks++;
    if (occupancy !== 2'd2) begin
      n_errors++;
      $display("FAIL rstpri_pre: occ=%0d need 2", occupancy);
    end
    rst = 1'b1;
    flush = 1'b1;
    e.pc = 32'h3028; e.data = mk_data(e.pc); e.bd = 1'b1; e.exc = 5'd8;
    drive_beat(e);
    @(posedge clk); #1;
    rst = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || out_pc !== 32'h3000 || out_data !== '0 || out_bd !== 1'b0 ||
        out_exc !== 5'd0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rstpri_state: valid=%b pc=%h bd=%b exc=%h occ=%0d rdy=%b, need 0 3000 0 0 0 1",
               out_valid, out_pc, out_bd, out_exc, occupancy, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL rstpri_after: valid=%b pending=%0d, need 0 0", out_valid, exp_q.size());
    end
  endtask

  task automatic test_noskid_stream();
    beat_t ei, eo;
    int sent, rcv, cyc;
    logic m_occ, m_ready;
    sent = 0; rcv = 0; cyc = 0; m_occ = 1'b0;
    ei.pc = 32'h5000; ei.data = mk_data(ei.pc); ei.bd = 1'b0; ei.exc = 5'd0;
    ns_in_valid = 1'b1; ns_in_pc = ei.pc; ns_in_data = ei.data; ns_in_bd = ei.bd; ns_in_exc = ei.exc;
    ns_out_ready = 1'b0;
    ns_q.push_back(ei);
    sent = 1;
    @(posedge clk); #1;
    m_occ = 1'b1;
    ns_in_valid = 1'b0;
    #1;
    n_checks++;
    if (ns_in_ready !== 1'b0 || ns_occupancy !== 2'd1 || ns_out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL ns_stall_ready: rdy=%b occ=%0d valid=%b, need 0 1 1", ns_in_ready, ns_occupancy, ns_out_valid);
    end
    ns_out_ready = 1'b1;
    #1;
    n_checks++;
    if (ns_in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ns_comb_ready: rdy=%b need 1", ns_in_ready);
    end
    while (rcv < 200 && cyc < 4000) begin
      cyc++;
      ns_out_ready = ($urandom_range(0, 3) != 0);
      if (sent < 200 && $urandom_range(0, 3) != 0) begin
        ei.pc = 32'h5000 + 32'(4 * sent);
        ei.data = mk_data(ei.pc);
        ei.bd = sent[0] ^ sent[1];
        ei.exc = 5'(sent);
        ns_in_valid = 1'b1; ns_in_pc = ei.pc; ns_in_data = ei.data;
        ns_in_bd = ei.bd; ns_in_exc = ei.exc;
      end else begin
        ns_in_valid = 1'b0;
      end
      #1;
      m_ready = !m_occ || ns_out_ready;
      n_checks++;
      if (ns_in_ready !== m_ready || ns_occupancy !== {1'b0, m_occ} || ns_out_valid !== m_occ) begin
        n_errors++;
        $display("FAIL ns_ctrl[%0d]: rdy=%b occ=%0d valid=%b, need %b %0d %b",
                 cyc, ns_in_ready, ns_occupancy, ns_out_valid, m_ready, m_occ, m_occ);
      end
      if (m_occ && ns_out_ready) begin
        n_checks++;
        if (ns_q.size() == 0) begin
          n_errors++;
          $display("FAIL ns_sb_empty[%0d]: scoreboard empty", cyc);
        end else begin
          eo = ns_q.pop_front();
          if (ns_out_pc !== eo.pc || ns_out_data !== eo.data || ns_out_bd !== eo.bd || ns_out_exc !== eo.exc) begin
            n_errors++;
            $display("FAIL ns_beat[%0d]: pc=%h bd=%b exc=%h, need %h %b %h",
                     cyc, ns_out_pc, ns_out_bd, ns_out_exc, eo.pc, eo.bd, eo.exc);
          end
        end
        rcv++;
      end
      if (ns_in_valid && m_ready) begin
        ns_q.push_back(ei);
        sent++;
        m_occ = 1'b1;
      end else if (m_occ && ns_out_ready) begin
        m_occ = 1'b0;
      end
      @(posedge clk); #1;
    end
    ns_in_valid = 1'b0;
    n_checks++;
    if (rcv != 200 || ns_q.size() != 0) begin
      n_errors++;
      $display("FAIL ns_total: received=%0d pending=%0d, need 200 0", rcv, ns_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush();
    test_bubble();
    test_rst_priority();
    test_noskid_stream();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
